// File: rtl/counter_enable_gen_if.sv
// counter_enable_gen_if: control and status signals of the enable-pulse generator.
// The optional start_err status is present only when COUNTER_ENABLE_GEN_START_ERR_EN is defined.
//
// Signalling: start and stop are level strobes sampled on every rising clk edge.
// There is no ready/ack. A start is accepted only while the generator is idle
// (busy low) and stop is low; otherwise it is dropped. All status outputs are
// registered and change only on a rising edge or on asynchronous reset.
interface counter_enable_gen_if #(
    parameter int PRESCALE_W = 8,
    parameter int BURST_W    = 8
);
    logic                  start;
    logic                  stop;
    logic [1:0]            mode;
    logic [PRESCALE_W-1:0] prescale;
    logic [BURST_W-1:0]    burst_len;
    logic                  enable;
    logic                  busy;
    logic                  done;
    logic [BURST_W-1:0]    pulse_cnt;
`ifdef COUNTER_ENABLE_GEN_START_ERR_EN
    logic                  start_err;

    modport master (
        output start, stop, mode, prescale, burst_len,
        input  enable, busy, done, pulse_cnt, start_err
    );
    modport slave (
        input  start, stop, mode, prescale, burst_len,
        output enable, busy, done, pulse_cnt, start_err
    );
`else
    modport master (
        output start, stop, mode, prescale, burst_len,
        input  enable, busy, done, pulse_cnt
    );
    modport slave (
        input  start, stop, mode, prescale, burst_len,
        output enable, busy, done, pulse_cnt
    );
`endif
endinterface

// File: rtl/counter_enable_gen.sv
// counter_enable_gen: prescaled single-cycle enable pulses for the downstream
// 4-bit counter.
// Modes: continuous, burst of N pulses, and single-shot.
// Optional macro COUNTER_ENABLE_GEN_START_ERR_EN adds a sticky start_err flag.
// The flag is raised when start arrives while the generator is busy.
// busy and done are registered copies of the previous cycle's state. As a result:
//   - done appears in the cycle after DONE was entered, which is the cycle after the last pulse.
//   - busy stays high until that cycle has ended.
module counter_enable_gen #(
    parameter int PRESCALE_W = 8,
    parameter int BURST_W    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    counter_enable_gen_if.slave bus,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [BURST_W-1:0]    CNT_ONE = BURST_W'(1);
    localparam logic [PRESCALE_W-1:0] DIV_ONE = PRESCALE_W'(1);

    state_t                state_q;
    logic [1:0]            mode_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [BURST_W-1:0]    len_q;
    logic [PRESCALE_W-1:0] divider_q;
    logic [BURST_W-1:0]    pulse_cnt_q;
    logic                  enable_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  accept;

    // A start is taken only from a fully idle generator with no concurrent stop.
    assign accept = (state_q == IDLE) && bus.start && !bus.stop && !busy_q;

    // Control FSM, divider, pulse counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mode_q      <= 2'b00;
            prescale_q  <= '0;
            len_q       <= '0;
            divider_q   <= '0;
            pulse_cnt_q <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            busy_q   <= (state_q != IDLE);
            done_q   <= (state_q == DONE);
            enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mode_q      <= bus.mode;
                        prescale_q  <= bus.prescale;
                        // Single-shot (and reserved) modes are treated as a burst of one.
                        if (bus.mode == 2'b01)
                            len_q <= (bus.burst_len == '0) ? CNT_ONE : bus.burst_len;
                        else
                            len_q <= CNT_ONE;
                        divider_q   <= bus.prescale;
                        pulse_cnt_q <= '0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        // Stop wins over a pulse due on this same edge.
                        state_q <= DONE;
                    end else if (divider_q == '0) begin
                        enable_q    <= 1'b1;
                        divider_q   <= prescale_q;
                        pulse_cnt_q <= pulse_cnt_q + CNT_ONE;
                        if ((mode_q != 2'b00) && (pulse_cnt_q == len_q - CNT_ONE))
                            state_q <= DONE;
                    end else begin
                        divider_q <= divider_q - DIV_ONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef COUNTER_ENABLE_GEN_START_ERR_EN
    logic start_err_q;

    // Sticky error flag. Set by start while busy; cleared by the next accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            start_err_q <= 1'b0;
        else if (accept)
            start_err_q <= 1'b0;
        else if (bus.start && busy_q)
            start_err_q <= 1'b1;
    end

    assign bus.start_err = start_err_q;
`endif

    assign bus.enable    = enable_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_cnt = pulse_cnt_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_counter_enable_gen.sv
// tb_counter_enable_gen: directed tests for counter_enable_gen.
// Cycle k denotes the interval after rising edge k. Edge 0 is the edge that accepts start.
// Inputs are driven and outputs are sampled on the falling edge.
// Optional macro COUNTER_ENABLE_GEN_START_ERR_EN enables the start_err checks.
module tb_counter_enable_gen;
    logic       clk;
    logic       reset_n;
    logic [1:0] state_dbg;
    int         tests_run;
    int         tests_failed;

    counter_enable_gen_if #(.PRESCALE_W(8), .BURST_W(8)) bus ();

    counter_enable_gen #(.PRESCALE_W(8), .BURST_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one full cycle, ending on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one start strobe. Returns in cycle 0 of the run.
    task automatic start_run(input logic [1:0] m, input logic [7:0] ps, input logic [7:0] len);
        bus.mode      = m;
        bus.prescale  = ps;
        bus.burst_len = len;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 2'b00;
        bus.prescale  = 8'd0;
        bus.burst_len = 8'd0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.enable !== 1'b0) begin tests_failed++; $display("FAIL reset_enable got=%b exp=0", bus.enable); end
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tests_run++;
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        tests_run++;
        if (bus.pulse_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_cnt got=%0d exp=0", bus.pulse_cnt); end
        tests_run++;
        if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        reset_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_continuous();
        logic exp_en;
        start_run(2'b00, 8'd3, 8'd0);
        for (int k = 0; k <= 12; k++) begin
            exp_en = (k == 4) || (k == 8) || (k == 12);
            tests_run++;
            if (bus.enable !== exp_en) begin tests_failed++; $display("FAIL cont_enable cyc=%0d got=%b exp=%b", k, bus.enable, exp_en); end
            if (k == 12) bus.stop = 1'b1;
            step();
        end
        bus.stop = 1'b0;
        tests_run++;
        if (bus.enable !== 1'b0) begin tests_failed++; $display("FAIL cont_stop_enable got=%b exp=0", bus.enable); end
        step();
        tests_run++;
        if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL cont_done cyc=14 got=%b exp=1", bus.done); end
        tests_run++;
        if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL cont_busy cyc=14 got=%b exp=1", bus.busy); end
        step();
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL cont_busy cyc=15 got=%b exp=0", bus.busy); end
        tests_run++;
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL cont_done cyc=15 got=%b exp=0", bus.done); end
        tests_run++;
        if (bus.pulse_cnt !== 8'd3) begin tests_failed++; $display("FAIL cont_cnt got=%0d exp=3", bus.pulse_cnt); end
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        logic exp_en;
        logic exp_done;
        logic exp_busy;
        int   busy_cycles;
        busy_cycles = 0;
        start_run(2'b01, 8'd0, 8'd5);
        for (int k = 0; k <= 8; k++) begin
            exp_en   = (k >= 1) && (k <= 5);
            exp_done = (k == 6);
            exp_busy = (k >= 1) && (k <= 6);
            if (bus.busy === 1'b1) busy_cycles++;
            tests_run++;
            if (bus.enable !== exp_en) begin tests_failed++; $display("FAIL b2b_enable cyc=%0d got=%b exp=%b", k, bus.enable, exp_en); end
            tests_run++;
            if (bus.done !== exp_done) begin tests_failed++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", k, bus.done, exp_done); end
            tests_run++;
            if (bus.busy !== exp_busy) begin tests_failed++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", k, bus.busy, exp_busy); end
            step();
        end
        tests_run++;
        if (busy_cycles != 6) begin tests_failed++; $display("FAIL b2b_busy_len got=%0d exp=6", busy_cycles); end
        tests_run++;
        if (bus.pulse_cnt !== 8'd5) begin tests_failed++; $display("FAIL b2b_cnt got=%0d exp=5", bus.pulse_cnt); end
        step();
    endtask

    task automatic test_single_shot();
        logic exp_en;
        int   en_count;
        start_run(2'b10, 8'd2, 8'd7);
        for (int k = 0; k <= 7; k++) begin
            exp_en = (k == 3);
            tests_run++;
            if (bus.enable !== exp_en) begin tests_failed++; $display("FAIL single_enable cyc=%0d got=%b exp=%b", k, bus.enable, exp_en); end
            tests_run++;
            if (bus.done !== (k == 4)) begin tests_failed++; $display("FAIL single_done cyc=%0d got=%b exp=%b", k, bus.done, (k == 4)); end
            step();
        end
        tests_run++;
        if (bus.pulse_cnt !== 8'd1) begin tests_failed++; $display("FAIL single_cnt got=%0d exp=1", bus.pulse_cnt); end
        // Zero burst length behaves as one pulse.
        en_count = 0;
        start_run(2'b01, 8'd1, 8'd0);
        for (int k = 0; k <= 9; k++) begin
            if (bus.enable === 1'b1) en_count++;
            step();
        end
        tests_run++;
        if (en_count != 1) begin tests_failed++; $display("FAIL zero_len_pulses got=%0d exp=1", en_count); end
        tests_run++;
        if (bus.pulse_cnt !== 8'd1) begin tests_failed++; $display("FAIL zero_len_cnt got=%0d exp=1", bus.pulse_cnt); end
        // Reserved mode behaves as single-shot.
        en_count = 0;
        start_run(2'b11, 8'd0, 8'd9);
        for (int k = 0; k <= 6; k++) begin
            if (bus.enable === 1'b1) en_count++;
            step();
        end
        tests_run++;
        if (en_count != 1) begin tests_failed++; $display("FAIL reserved_pulses got=%0d exp=1", en_count); end
    endtask

    task automatic test_stop_collision();
        start_run(2'b00, 8'd1, 8'd0);
        step(); step();
        tests_run++;
        if (bus.enable !== 1'b1) begin tests_failed++; $display("FAIL coll_first_pulse cyc=2 got=%b exp=1", bus.enable); end
        step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        tests_run++;
        if (bus.enable !== 1'b0) begin tests_failed++; $display("FAIL coll_suppressed cyc=4 got=%b exp=0", bus.enable); end
        tests_run++;
        if (bus.pulse_cnt !== 8'd1) begin tests_failed++; $display("FAIL coll_cnt got=%0d exp=1", bus.pulse_cnt); end
        step();
        tests_run++;
        if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL coll_done cyc=5 got=%b exp=1", bus.done); end
        repeat (3) step();
        tests_run++;
        if (bus.pulse_cnt !== 8'd1) begin tests_failed++; $display("FAIL coll_cnt_hold got=%0d exp=1", bus.pulse_cnt); end
    endtask

    task automatic test_idle_collision();
        int en_count;
        int busy_count;
        en_count   = 0;
        busy_count = 0;
        bus.stop = 1'b1;
        start_run(2'b00, 8'd0, 8'd0);
        bus.stop = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (bus.enable === 1'b1) en_count++;
            if (bus.busy === 1'b1) busy_count++;
            step();
        end
        tests_run++;
        if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL idle_coll_state got=%0d exp=0", state_dbg); end
        tests_run++;
        if (en_count != 0) begin tests_failed++; $display("FAIL idle_coll_enable got=%0d exp=0", en_count); end
        tests_run++;
        if (busy_count != 0) begin tests_failed++; $display("FAIL idle_coll_busy got=%0d exp=0", busy_count); end
    endtask

    task automatic test_reset_mid_run();
        int en_count;
        en_count = 0;
        start_run(2'b01, 8'd0, 8'd10);
        repeat (3) step();
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (bus.enable !== 1'b0) begin tests_failed++; $display("FAIL midrst_enable got=%b exp=0", bus.enable); end
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        tests_run++;
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
        tests_run++;
        if (bus.pulse_cnt !== 8'd0) begin tests_failed++; $display("FAIL midrst_cnt got=%0d exp=0", bus.pulse_cnt); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.enable === 1'b1) en_count++;
        end
        tests_run++;
        if (en_count != 0) begin tests_failed++; $display("FAIL midrst_after got=%0d exp=0", en_count); end
    endtask

    task automatic test_start_while_busy();
        int en_count;
        en_count = 0;
        start_run(2'b01, 8'd1, 8'd3);
        for (int k = 0; k <= 12; k++) begin
            if (bus.enable === 1'b1) en_count++;
            tests_run++;
            if (bus.done !== (k == 7)) begin tests_failed++; $display("FAIL swb_done cyc=%0d got=%b exp=%b", k, bus.done, (k == 7)); end
            if (k == 2) begin
                bus.start     = 1'b1;
                bus.mode      = 2'b00;
                bus.prescale  = 8'd0;
                bus.burst_len = 8'd9;
            end
            if (k == 3) bus.start = 1'b0;
`ifdef COUNTER_ENABLE_GEN_START_ERR_EN
            tests_run++;
            if (bus.start_err !== (k >= 3)) begin tests_failed++; $display("FAIL swb_err cyc=%0d got=%b exp=%b", k, bus.start_err, (k >= 3)); end
`endif
            step();
        end
        tests_run++;
        if (en_count != 3) begin tests_failed++; $display("FAIL swb_pulses got=%0d exp=3", en_count); end
        tests_run++;
        if (bus.pulse_cnt !== 8'd3) begin tests_failed++; $display("FAIL swb_cnt got=%0d exp=3", bus.pulse_cnt); end
`ifdef COUNTER_ENABLE_GEN_START_ERR_EN
        start_run(2'b10, 8'd0, 8'd0);
        tests_run++;
        if (bus.start_err !== 1'b0) begin tests_failed++; $display("FAIL swb_err_clear got=%b exp=0", bus.start_err); end
        repeat (5) step();
`endif
    endtask

    // Test sequence and summary.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        @(negedge clk);
        test_reset();
        test_continuous();
        test_back_to_back();
        test_single_shot();
        test_stop_collision();
        test_idle_collision();
        test_reset_mid_run();
        test_start_while_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/counter_enable_gen.md
Name: counter_enable_gen

Overview:
- Programmable enable-pulse generator sitting directly upstream of the 4-bit enable/reset counter.
- Drives the counter's `enable` input with prescaled single-cycle pulses.
- Three operating modes: continuous, burst of N pulses, single-shot.
- Software/sequence control via start/stop strobes; reports busy, done and the pulse count of the current run.

Parameters:
- PRESCALE_W, 8, width of prescale input; pulse period = prescale+1 clocks.
- BURST_W, 8, width of burst_len input and pulse_cnt output.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  run request strobe, sampled on rising edge.
- stop  input  1  abort/terminate strobe, sampled on rising edge.
- mode  input  2  00 continuous, 01 burst, 10 single-shot, 11 reserved (behaves as single-shot).
- prescale  input  PRESCALE_W  period minus one.
- burst_len  input  BURST_W  pulses per burst; 0 treated as 1.
- enable  output  1  registered enable pulse to counter.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse marking end of run.
- pulse_cnt  output  BURST_W  pulses issued in current/last run.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is asynchronous, active-low (reset_n).
  - While reset_n is low: state IDLE; enable=0, busy=0, done=0, pulse_cnt=0; internal divider and latched config cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and stop=0 at edge E: latch mode/prescale/burst_len, load divider=prescale, clear pulse_cnt, go RUN.
  - start and stop high together: stay IDLE.
- RUN, divider and pulses:
  - Divider decrements each clock.
  - At divider==0: enable=1 for the next cycle only, divider reloads latched prescale, pulse_cnt increments.
- RUN, timing:
  - First enable cycle begins prescale+1 clocks after edge E; subsequent pulses every prescale+1 clocks.
  - prescale=0 gives enable continuously high, one pulse per clock.
- RUN, termination:
  - Burst: after burst_len pulses issued, the next state is DONE.
  - Single-shot: after 1 pulse, the next state is DONE.
  - Continuous: runs until stop; pulse_cnt wraps modulo 2^BURST_W.
- stop in RUN:
  - Sampled high at edge S: no enable asserted in the cycle after S; go DONE.
  - Stop coinciding with a pending pulse suppresses that pulse; pulse_cnt not incremented.
- DONE:
  - Lasts exactly one cycle: done=1, enable=0, then IDLE.
  - pulse_cnt holds its final value until the next accepted start.
- start while busy: ignored; latched config unchanged.
- Config input changes during RUN have no effect.
- All outputs registered; no combinational input-to-output path.

Optional Feature:
- Macro: COUNTER_ENABLE_GEN_START_ERR_EN.
- Defined:
  - Adds output start_err (1 bit, reset 0).
  - Sticky high once start is sampled high while busy=1.
  - Cleared only by an accepted start in IDLE or by reset_n.
- Undefined:
  - Port absent; start while busy silently ignored.
  - All other behaviour identical.

Test Plan:
- Continuous: mode=00, prescale=3, start at edge 0 -> enable high in cycles 4, 8, 12; stop at edge 13 -> no further enable, done=1 in cycle 14, busy=0 from cycle 15, pulse_cnt=3.
- Burst back-to-back: mode=01, prescale=0, burst_len=5, start -> enable high for 5 consecutive cycles, done one cycle later, pulse_cnt=5, busy high 6 cycles total.
- Single-shot and zero burst length:
  - mode=10, prescale=2 -> exactly one enable at cycle 3, then done.
  - mode=01, burst_len=0 -> exactly one pulse.
- Stop collision and idle collision:
  - Stop at the same edge a pulse would fire (prescale=1, continuous) -> pulse suppressed, pulse_cnt unchanged.
  - start+stop together in IDLE -> remains IDLE.
- Reset mid-run: assert reset_n low asynchronously mid-burst -> enable, busy, done, pulse_cnt go 0 immediately; after release, no enable until a new start.
- Start while busy:
  - Start pulsed during RUN -> ignored, burst completes with original config.
  - With COUNTER_ENABLE_GEN_START_ERR_EN defined, start_err=1 and stays 1 until the next accepted start.
